stream_decipher: RTL and testbench

Receive-side companion of the stream cipher: accepts ciphertext bytes on `ui_in`, each strobed in by the host, and XORs them with a 16-bit Galois-LFSR keystream to recover plaintext on `uo_out`. The block holds the key-load, resync and byte-strobe state needed to stay in lock-step with the transmitting cipher. It uses the standard TinyTapeout user-project port set.

---
 rtl/stream_decipher_pkg.sv | 29 ++
 rtl/stream_decipher_lfsr_keystream.sv | 32 +++
 rtl/stream_decipher.sv | 170 +++++++++++++++++
 tb/tb_stream_decipher.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_decipher_pkg.sv
// Shared definitions for the stream_decipher block: FSM state encoding,
// bit positions within the uio control/status buses and default constants.
package stream_decipher_pkg;

   typedef enum logic [1:0] {
      NOKEY  = 2'd0,
      KEY_LO = 2'd1,
      READY  = 2'd2
   } state_t;

   // uio_in control bit positions
   localparam int STRB      = 0;
   localparam int KEY       = 1;
   localparam int RESYNC    = 2;
   localparam int VIEW      = 3;

   // uio_out status bit positions
   localparam int OUT_VALID = 4;
   localparam int LOCKED    = 5;
   localparam int KEY_HALF  = 6;
   localparam int ERR       = 7;

   localparam logic [15:0] DEF_TAPS = 16'hB400;
   localparam logic [15:0] DEF_SEED = 16'hACE1;

   // Upper nibble of uio is always driven as status outputs.
   localparam logic [7:0] UIO_OE = 8'hF0;

endpackage

// File: rtl/stream_decipher_lfsr_keystream.sv
// Galois LFSR keystream generator. A load of an all-zero value is replaced
// by SEED_DEFAULT so the register can never lock up in the zero state.
module lfsr_keystream
   import stream_decipher_pkg::*;
#(
   parameter int                LFSR_W       = 16,
   parameter logic [LFSR_W-1:0] TAPS         = DEF_TAPS,
   parameter logic [LFSR_W-1:0] SEED_DEFAULT = DEF_SEED
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   input  logic              step,
   output logic [LFSR_W-1:0] state
);

   // Load has priority over step; the register holds while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEED_DEFAULT;
      end else if (ena) begin
         if (load) begin
            state <= (load_val == '0) ? SEED_DEFAULT : load_val;
         end else if (step) begin
            state <= (state >> 1) ^ (state[0] ? TAPS : '0);
         end
      end
   end

endmodule

// File: rtl/stream_decipher.sv
// stream_decipher: receive-side stream cipher. Strobed ciphertext bytes are
// XORed with a 16-bit Galois LFSR keystream after a two-byte key load.
// Optional feature macro: STREAM_DECIPHER_VIEW_EN (uio_in[3] selects the
// byte counter onto uo_out); when undefined the counter is not built.
module stream_decipher
   import stream_decipher_pkg::*;
#(
   parameter int                LFSR_W       = 16,
   parameter logic [LFSR_W-1:0] TAPS         = DEF_TAPS,
   parameter logic [LFSR_W-1:0] SEED_DEFAULT = DEF_SEED
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   state_t            st, st_d;
   logic              strb_q, rs_q;
   logic              strb_p, rs_p;
   logic [LFSR_W-1:0] key_r, key_d;
   logic [7:0]        pt_r, pt_d;
   logic              err_r, err_d;
   logic              vld_r, vld_d;
   logic              locked_r, key_half_r;
   logic              lfsr_load, lfsr_step, cnt_clr, cnt_inc;
   logic [LFSR_W-1:0] lfsr_load_val;
   logic [LFSR_W-1:0] ks;
   logic              unused_bits;

   assign uio_oe = UIO_OE;

   // Edges only count while enabled, so a frozen history never fires.
   assign strb_p = ena & uio_in[STRB]   & ~strb_q;
   assign rs_p   = ena & uio_in[RESYNC] & ~rs_q;

   lfsr_keystream #(
      .LFSR_W       (LFSR_W),
      .TAPS         (TAPS),
      .SEED_DEFAULT (SEED_DEFAULT)
   ) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .load     (lfsr_load),
      .load_val (lfsr_load_val),
      .step     (lfsr_step),
      .state    (ks)
   );

   // Next-state decode; a resync edge pre-empts any simultaneous strobe.
   always_comb begin
      st_d          = st;
      key_d         = key_r;
      pt_d          = pt_r;
      err_d         = err_r;
      vld_d         = 1'b0;
      lfsr_load     = 1'b0;
      lfsr_load_val = key_r;
      lfsr_step     = 1'b0;
      cnt_clr       = 1'b0;
      cnt_inc       = 1'b0;
      if (rs_p) begin
         if (st == READY) begin
            lfsr_load = 1'b1;
            cnt_clr   = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end else if (strb_p) begin
         case (st)
            NOKEY: begin
               if (uio_in[KEY]) begin
                  key_d[15:8] = ui_in;
                  st_d        = KEY_LO;
               end else begin
                  err_d = 1'b1;
               end
            end
            KEY_LO: begin
               if (uio_in[KEY]) begin
                  key_d[7:0]    = ui_in;
                  lfsr_load     = 1'b1;
                  lfsr_load_val = {key_r[15:8], ui_in};
                  cnt_clr       = 1'b1;
                  st_d          = READY;
               end else begin
                  err_d = 1'b1;
               end
            end
            READY: begin
               if (uio_in[KEY]) begin
                  key_d[15:8] = ui_in;
                  st_d        = KEY_LO;
               end else begin
                  pt_d      = ui_in ^ ks[7:0];
                  lfsr_step = 1'b1;
                  cnt_inc   = 1'b1;
                  vld_d     = 1'b1;
               end
            end
            default: st_d = NOKEY;
         endcase
      end
   end

   // Control and output registers; everything holds while ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st         <= NOKEY;
         strb_q     <= 1'b0;
         rs_q       <= 1'b0;
         key_r      <= '0;
         pt_r       <= '0;
         err_r      <= 1'b0;
         vld_r      <= 1'b0;
         locked_r   <= 1'b0;
         key_half_r <= 1'b0;
      end else if (ena) begin
         st         <= st_d;
         strb_q     <= uio_in[STRB];
         rs_q       <= uio_in[RESYNC];
         key_r      <= key_d;
         pt_r       <= pt_d;
         err_r      <= err_d;
         vld_r      <= vld_d;
         locked_r   <= (st_d == READY);
         key_half_r <= (st_d == KEY_LO);
      end else begin
         vld_r      <= 1'b0;
      end
   end

`ifdef STREAM_DECIPHER_VIEW_EN
   logic [7:0] cnt_r, cnt_d, uo_r;

   assign cnt_d = cnt_clr ? 8'd0 : (cnt_inc ? cnt_r + 8'd1 : cnt_r);

   // Byte counter (wraps silently) and the view-selected output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
         uo_r  <= '0;
      end else if (ena) begin
         cnt_r <= cnt_d;
         uo_r  <= uio_in[VIEW] ? cnt_d : pt_d;
      end
   end

   assign uo_out = uo_r;
`else
   assign uo_out = pt_r;
`endif

   // Status bus assembly; low nibble is always zero.
   always_comb begin
      uio_out            = '0;
      uio_out[OUT_VALID] = vld_r;
      uio_out[LOCKED]    = locked_r;
      uio_out[KEY_HALF]  = key_half_r;
      uio_out[ERR]       = err_r;
   end

   assign unused_bits = ^{ks[LFSR_W-1:8], uio_in[7:4], uio_in[VIEW], cnt_clr, cnt_inc};

endmodule

// File: tb/tb_stream_decipher.sv
// Directed testbench for stream_decipher with hand-computed vectors.
module tb_stream_decipher;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks   = 0;
   int failures = 0;

   logic [7:0] seen_uo, seen_uio;
   int         vld_cnt;

   stream_decipher dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, act, exp);
      end
   endtask

   // One strobe: high for one sampled edge, outputs captured after that edge.
   task automatic strobe(input logic [7:0] b, input logic k);
      @(negedge clk);
      ui_in     = b;
      uio_in[1] = k;
      uio_in[0] = 1'b1;
      @(negedge clk);
      uio_in[0] = 1'b0;
      seen_uo   = uo_out;
      seen_uio  = uio_out;
   endtask

   task automatic resync_pulse();
      @(negedge clk);
      uio_in[2] = 1'b1;
      @(negedge clk);
      uio_in[2] = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic load_key(input logic [7:0] hi, input logic [7:0] lo);
      strobe(hi, 1'b1);
      strobe(lo, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_uo", uo_out, 8'h00);
      check("rst_uio", uio_out, 8'h00);
      check("rst_oe", uio_oe, 8'hF0);
      rst_n = 1'b1;

      // Key load 0xACE1
      strobe(8'hAC, 1'b1);
      check("key_half", seen_uio, 8'h40);
      strobe(8'hE1, 1'b1);
      check("locked", seen_uio, 8'h20);

      // First byte: FF ^ E1 = 1E
      strobe(8'hFF, 1'b0);
      check("dec1_uo", seen_uo, 8'h1E);
      check("dec1_vld", seen_uio, 8'h30);
      @(negedge clk);
      check("vld_one_cycle", uio_out, 8'h20);
      // LFSR now E270: 70 ^ 70 = 00
      strobe(8'h70, 1'b0);
      check("dec2_uo", seen_uo, 8'h00);

      // Resync returns to the key start
      resync_pulse();
      strobe(8'hFF, 1'b0);
      check("resync_uo", seen_uo, 8'h1E);

      // Resync and strobe rising together: strobe discarded, no err
      @(negedge clk);
      uio_in[0] = 1'b1;
      uio_in[2] = 1'b1;
      ui_in     = 8'h55;
      @(negedge clk);
      check("rs_strb_uio", uio_out, 8'h20);
      check("rs_strb_uo", uo_out, 8'h1E);
      uio_in[0] = 1'b0;
      uio_in[2] = 1'b0;

      // Held strobe: one byte only. LFSR reloaded to ACE1, then stepped once.
      strobe(8'hFF, 1'b0);
      check("after_rs_uo", seen_uo, 8'h1E);
      @(negedge clk);
      ui_in     = 8'hFF;
      uio_in[0] = 1'b1;
      vld_cnt   = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (uio_out[4]) vld_cnt++;
      end
      uio_in[0] = 1'b0;
      check("held_vld_count", vld_cnt[15:0], 16'd1);
      check("held_uo", uo_out, 8'h8F);

      // ena low: toggling strobe must do nothing, also after re-enable
      @(negedge clk);
      ena     = 1'b0;
      vld_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         uio_in[0] = ~uio_in[0];
         if (uio_out[4]) vld_cnt++;
      end
      uio_in[0] = 1'b0;
      @(negedge clk);
      ena = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (uio_out[4]) vld_cnt++;
      end
      check("ena_vld_count", vld_cnt[15:0], 16'd0);
      check("ena_uo", uo_out, 8'h8F);

      // Key byte in READY restarts loading
      strobe(8'h12, 1'b1);
      check("rekey_uio", seen_uio, 8'h40);

      // Reset mid-load, then a data strobe in NOKEY
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_uo", uo_out, 8'h00);
      check("midrst_uio", uio_out, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      strobe(8'hFF, 1'b0);
      check("nokey_err", seen_uio, 8'h80);
      check("nokey_uo", seen_uo, 8'h00);

      // Zero key behaves like ACE1
      do_reset();
      load_key(8'h00, 8'h00);
      check("zkey_uio", seen_uio, 8'h20);
      strobe(8'hFF, 1'b0);
      check("zkey_uo", seen_uo, 8'h1E);

      // Resync outside READY is an error
      do_reset();
      resync_pulse();
      @(negedge clk);
      check("rs_nokey_err", uio_out, 8'h80);

`ifdef STREAM_DECIPHER_VIEW_EN
      do_reset();
      load_key(8'hAC, 8'hE1);
      strobe(8'hFF, 1'b0);
      strobe(8'h70, 1'b0);
      strobe(8'h00, 1'b0);
      @(negedge clk);
      uio_in[3] = 1'b1;
      @(negedge clk);
      check("view_cnt3", uo_out, 8'h03);
      uio_in[3] = 1'b0;
      resync_pulse();
      strobe(8'hFF, 1'b0);
      check("view_pt", seen_uo, 8'h1E);
      @(negedge clk);
      uio_in[3] = 1'b1;
      @(negedge clk);
      check("view_cnt_rs", uo_out, 8'h01);
      uio_in[3] = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
